// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one N-bit ALU between two requesters.
// One operation in flight at a time; operands and results are registered.
module alu_arbiter #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic [2:0]   req0_op,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic [2:0]   req1_op,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic [N-1:0] rsp0_c,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [N-1:0] rsp1_c,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic         gnt_c;
  logic         accept_c;
  logic         gnt_q;
  logic         last_q;
  logic [N-1:0] a_q;
  logic [N-1:0] b_q;
  logic [2:0]   op_q;
  logic [N-1:0] alu_c;

  // Grant selection, request handshake and next-state logic
  always_comb begin
    state_nxt  = state;
    gnt_c      = 1'b0;
    accept_c   = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        if (req0_valid && req1_valid) begin
          gnt_c = ~last_q;
        end else begin
          gnt_c = req1_valid;
        end
        // ready is withheld while reset is asserted so all handshakes read 0
        accept_c   = (req0_valid | req1_valid) & ~rst;
        req0_ready = accept_c & ~gnt_c;
        req1_ready = accept_c & gnt_c;
        if (accept_c) begin
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        state_nxt = RESP;
      end
      RESP: begin
        if (gnt_q ? rsp1_ready : rsp0_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Shared ALU on the latched operands; results truncated to N bits
  always_comb begin
    case (op_q)
      3'b000:  alu_c = a_q + b_q;
      3'b001:  alu_c = a_q - b_q;
      3'b010:  alu_c = N'(a_q * b_q);
      3'b011:  alu_c = a_q & b_q;
      default: alu_c = a_q | b_q;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand latch, round-robin pointer and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= 3'b000;
      gnt_q      <= 1'b0;
      last_q     <= 1'b1;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_c     <= '0;
      rsp1_c     <= '0;
    end else begin
      if (accept_c) begin
        a_q    <= gnt_c ? req1_a : req0_a;
        b_q    <= gnt_c ? req1_b : req0_b;
        op_q   <= gnt_c ? req1_op : req0_op;
        gnt_q  <= gnt_c;
        last_q <= gnt_c;
      end
      if (state == EXEC) begin
        if (gnt_q) begin
          rsp1_c     <= alu_c;
          rsp1_valid <= 1'b1;
        end else begin
          rsp0_c     <= alu_c;
          rsp0_valid <= 1'b1;
        end
      end
      if (state == RESP) begin
        if (gnt_q && rsp1_ready) begin
          rsp1_valid <= 1'b0;
        end
        if (!gnt_q && rsp0_ready) begin
          rsp0_valid <= 1'b0;
        end
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vectors plus a transaction-level reference model
// compared against the DUT on every falling clock edge.
module tb_alu_arbiter;

  logic       clk;
  logic       rst;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_op, req1_op;
  logic       rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [7:0] rsp0_c, rsp1_c;
  logic       busy;

  logic       f_req0_valid, f_req1_valid, f_req0_ready, f_req1_ready;
  logic [3:0] f_req0_a, f_req0_b, f_req1_a, f_req1_b;
  logic [2:0] f_req0_op, f_req1_op;
  logic       f_rsp0_valid, f_rsp1_valid, f_rsp0_ready, f_rsp1_ready;
  logic [3:0] f_rsp0_c, f_rsp1_c;
  logic       f_busy;

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.N(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_c(rsp0_c),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_c(rsp1_c),
    .busy(busy)
  );

  alu_arbiter #(.N(4)) dut4 (
    .clk(clk), .rst(rst),
    .req0_valid(f_req0_valid), .req0_ready(f_req0_ready), .req0_a(f_req0_a), .req0_b(f_req0_b), .req0_op(f_req0_op),
    .req1_valid(f_req1_valid), .req1_ready(f_req1_ready), .req1_a(f_req1_a), .req1_b(f_req1_b), .req1_op(f_req1_op),
    .rsp0_valid(f_rsp0_valid), .rsp0_ready(f_rsp0_ready), .rsp0_c(f_rsp0_c),
    .rsp1_valid(f_rsp1_valid), .rsp1_ready(f_rsp1_ready), .rsp1_c(f_rsp1_c),
    .busy(f_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  // Reference ALU from the opcode table, reduced modulo 2^n
  function automatic int alu_ref(input int a, input int b, input int op, input int n);
    int r;
    int m;
    m = 1 << n;
    case (op)
      0:       r = a + b;
      1:       r = a - b;
      2:       r = a * b;
      3:       r = a & b;
      default: r = a | b;
    endcase
    return ((r % m) + m) % m;
  endfunction

  // Transaction model: an accepted job owns the ALU, its result shows one
  // cycle later and is retired by the owner's response ready.
  int m_inflight, m_owner, m_age, m_last, m_res;
  int m_hold[2];

  always @(negedge clk) begin
    int  g;
    bit  e_r0, e_r1;
    if (rst) begin
      m_inflight = 0; m_owner = 0; m_age = 0; m_last = 1; m_res = 0;
      m_hold[0] = 0; m_hold[1] = 0;
    end
    g = 0; e_r0 = 1'b0; e_r1 = 1'b0;
    if (!rst && m_inflight == 0) begin
      if (req0_valid && req1_valid) g = 1 - m_last;
      else g = req1_valid ? 1 : 0;
      e_r0 = req0_valid && (g == 0);
      e_r1 = req1_valid && (g == 1);
    end
    chk("cmp_req0_ready", req0_ready, e_r0);
    chk("cmp_req1_ready", req1_ready, e_r1);
    chk("cmp_busy", busy, m_inflight != 0);
    chk("cmp_rsp0_valid", rsp0_valid, m_inflight != 0 && m_age >= 1 && m_owner == 0);
    chk("cmp_rsp1_valid", rsp1_valid, m_inflight != 0 && m_age >= 1 && m_owner == 1);
    chk("cmp_rsp0_c", rsp0_c, m_hold[0]);
    chk("cmp_rsp1_c", rsp1_c, m_hold[1]);
    if (!rst) begin
      if (m_inflight == 0) begin
        if (req0_valid || req1_valid) begin
          m_inflight = 1; m_owner = g; m_last = g; m_age = 0;
          m_res = (g == 1) ? alu_ref(int'(req1_a), int'(req1_b), int'(req1_op), 8)
                           : alu_ref(int'(req0_a), int'(req0_b), int'(req0_op), 8);
        end
      end else if (m_age == 0) begin
        m_age = 1;
        m_hold[m_owner] = m_res;
      end else if ((m_owner == 1) ? rsp1_ready : rsp0_ready) begin
        m_inflight = 0;
      end
    end
  end

  // Single operation on the 8-bit DUT, checks accept, 2-edge latency and value
  task automatic run_op(input bit id, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] op, input logic [7:0] exp, input string nm);
    int n;
    bit got;
    if (id) begin req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1; end
    else    begin req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1; end
    n = 0; got = 1'b0;
    while (!got && n < 10) begin
      @(negedge clk); n++;
      got = id ? req1_ready : req0_ready;
    end
    chk({nm, "_accept"}, got, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    n = 0; got = 1'b0;
    while (!got && n < 10) begin
      @(negedge clk); n++;
      got = id ? rsp1_valid : rsp0_valid;
    end
    chk({nm, "_rsp_valid"}, got, 1);
    chk({nm, "_latency"}, n, 2);
    chk(nm, id ? rsp1_c : rsp0_c, exp);
    chk({nm, "_busy"}, busy, 1);
    @(posedge clk); #1;
  endtask

  // Single operation on the 4-bit DUT
  task automatic run4(input bit id, input logic [3:0] a, input logic [3:0] b,
                      input logic [2:0] op, input logic [3:0] exp, input string nm);
    int n;
    bit got;
    if (id) begin f_req1_a = a; f_req1_b = b; f_req1_op = op; f_req1_valid = 1'b1; end
    else    begin f_req0_a = a; f_req0_b = b; f_req0_op = op; f_req0_valid = 1'b1; end
    n = 0; got = 1'b0;
    while (!got && n < 10) begin
      @(negedge clk); n++;
      got = id ? f_req1_ready : f_req0_ready;
    end
    chk({nm, "_accept"}, got, 1);
    @(posedge clk); #1;
    f_req0_valid = 1'b0; f_req1_valid = 1'b0;
    n = 0; got = 1'b0;
    while (!got && n < 10) begin
      @(negedge clk); n++;
      got = id ? f_rsp1_valid : f_rsp0_valid;
    end
    chk({nm, "_rsp_valid"}, got, 1);
    chk(nm, id ? f_rsp1_c : f_rsp0_c, exp);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    bit idle;
    n = 0; idle = 1'b0;
    while (!idle && n < 20) begin
      @(negedge clk); n++;
      idle = !busy;
    end
    chk(nm, idle, 1);
    @(posedge clk); #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int       n, k;
    bit       got;
    logic [3:0] order;
    rst = 1'b0;
    req0_valid = 0; req1_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0;
    req1_a = 0; req1_b = 0; req1_op = 0; rsp0_ready = 0; rsp1_ready = 0;
    f_req0_valid = 0; f_req1_valid = 0; f_req0_a = 0; f_req0_b = 0; f_req0_op = 0;
    f_req1_a = 0; f_req1_b = 0; f_req1_op = 0; f_rsp0_ready = 1; f_rsp1_ready = 1;
    #2 rst = 1'b1;

    // Hand-computed values pinning the reference ALU
    chk("model_add_wrap", alu_ref(200, 100, 0, 8), 44);
    chk("model_sub_wrap", alu_ref(5, 7, 1, 8), 8'hFE);
    chk("model_mul_trunc", alu_ref(16, 17, 2, 8), 8'h10);
    chk("model_and", alu_ref(8'hF0, 8'h3C, 3, 8), 8'h30);
    chk("model_or_default", alu_ref(8'h0F, 8'hA0, 7, 8), 8'hAF);
    chk("model_n4_mul", alu_ref(9, 9, 2, 4), 1);
    chk("model_n4_sub", alu_ref(0, 1, 1, 4), 4'hF);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_rsp0_valid", rsp0_valid, 0);
    chk("reset_rsp1_valid", rsp1_valid, 0);
    chk("reset_rsp0_c", rsp0_c, 0);
    chk("reset_rsp1_c", rsp1_c, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single add with wrap
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    run_op(1'b0, 8'd200, 8'd100, 3'b000, 8'd44, "add_wrap");

    // Tie and fairness from a fresh pointer
    pulse_rst();
    req0_a = 8'd5;  req0_b = 8'd7;  req0_op = 3'b001;
    req1_a = 8'd16; req1_b = 8'd17; req1_op = 3'b010;
    req0_valid = 1'b1; req1_valid = 1'b1;
    order = 4'b0000; k = 0; n = 0;
    while (k < 4 && n < 40) begin
      @(negedge clk); n++;
      if (rsp0_valid) chk("rr_sub_wrap", rsp0_c, 8'hFE);
      if (rsp1_valid) chk("rr_mul_trunc", rsp1_c, 8'h10);
      if (req0_ready) begin order[k] = 1'b0; k++; end
      else if (req1_ready) begin order[k] = 1'b1; k++; end
    end
    chk("rr_count", k, 4);
    chk("rr_order", order, 4'b1010);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle("rr_drain");

    // Back-pressure on requester 1 while requester 0 waits
    rsp1_ready = 1'b0;
    req1_a = 8'hF0; req1_b = 8'h3C; req1_op = 3'b011; req1_valid = 1'b1;
    n = 0; got = 1'b0;
    while (!got && n < 10) begin @(negedge clk); n++; got = req1_ready; end
    chk("bp_accept", got, 1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    req0_a = 8'h0F; req0_b = 8'hA0; req0_op = 3'b111; req0_valid = 1'b1;
    rsp0_ready = 1'b1;
    n = 0; got = 1'b0;
    while (!got && n < 10) begin @(negedge clk); n++; got = rsp1_valid; end
    chk("bp_rsp_valid", got, 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid_held", rsp1_valid, 1);
      chk("bp_and_stable", rsp1_c, 8'h30);
      chk("bp_req0_blocked", req0_ready, 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    rsp1_ready = 1'b1;
    @(negedge clk);
    chk("bp_req0_blocked_last", req0_ready, 0);
    @(negedge clk);
    chk("bp_regrant_req0", req0_ready, 1);
    chk("bp_rsp1_cleared", rsp1_valid, 0);
    chk("bp_rsp1_c_kept", rsp1_c, 8'h30);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    n = 0; got = 1'b0;
    while (!got && n < 10) begin @(negedge clk); n++; got = rsp0_valid; end
    chk("or_default_valid", got, 1);
    chk("or_default", rsp0_c, 8'hAF);
    wait_idle("bp_drain");

    // Reset while in EXEC discards the operation
    req0_a = 8'd1; req0_b = 8'd2; req0_op = 3'b000; req0_valid = 1'b1;
    n = 0; got = 1'b0;
    while (!got && n < 10) begin @(negedge clk); n++; got = req0_ready; end
    chk("mid_rst_accept", got, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    chk("mid_rst_exec_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy_async", busy, 0);
    chk("mid_rst_rsp0_valid", rsp0_valid, 0);
    repeat (2) begin
      @(negedge clk);
      chk("mid_rst_no_rsp0", rsp0_valid, 0);
      chk("mid_rst_no_rsp1", rsp1_valid, 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    req1_a = 8'd3; req1_b = 8'd4; req1_op = 3'b000;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    chk("post_rst_tie_req0", req0_ready, 1);
    chk("post_rst_tie_req1", req1_ready, 0);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle("post_rst_drain");

    // Narrow instance
    run4(1'b0, 4'd9, 4'd9, 3'b010, 4'd1, "n4_mul_trunc");
    run4(1'b1, 4'd0, 4'd1, 3'b001, 4'hF, "n4_sub_wrap");

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
